pipelined_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the core datapath; successor to the HA/FA adder cells.

---
 rtl/pipelined_adder_pkg.sv | 10 +
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/pipelined_adder_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 110 +++++++++++
 tb/tb_pipelined_adder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared opcode encodings and configuration check for the pipelined add/subtract unit
//    OP_ADD / OP_SUB : encodings of the sub select (0 = add, 1 = subtract)
//    cfg_ok()        : legal WIDTH/STAGES combination (1 <= STAGES <= WIDTH, WIDTH divisible by STAGES)
package pipelined_adder_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   function automatic bit cfg_ok(input int width, input int stages);
      return stages >= 1 && stages <= width && width % stages == 0;
   endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle of the pipelined adder
//    in_valid/in_ready   : operand transfer handshake (A, B, Cin, sub)
//    out_valid/out_ready : result transfer handshake (Y, Cout, ovf, zero)
//    master : producer/consumer side (testbench, datapath), slave : the adder
interface pipelined_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic             Cout;
   logic             ovf;
   logic             zero;
   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, Y, Cout, ovf, zero
   );
   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, Y, Cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_adder_slice.sv
// pipelined_adder_slice: combinational CHUNK-bit ripple adder built from a chain of full-adder cells
//    a, b : chunk operands     cin  : carry into bit 0
//    s    : chunk sum          cout : carry out of the chunk MSB
module pipelined_adder_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);
   logic c;
   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-chained slices, one slice per clock
//    clk, rst_n : clock (rising edge), asynchronous active-low reset
//    bus.slave  : in_valid/in_ready + A, B, Cin, sub  ->  out_valid/out_ready + Y, Cout, ovf, zero
//    sub=0: Y = A + B + Cin ; sub=1: Y = A - B - Cin (Cout = 1 means no borrow)
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic              clk,
   input logic              rst_n,
   pipelined_adder_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int L     = STAGES - 1;
   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
   end
   logic             en;
   logic [WIDTH-1:0] bx;
   logic             c0;
   logic             ovf_q;
   logic             has_q;
   // subtraction is A + ~B + ~Cin, so a borrow-in becomes a missing carry-in
   assign bx = (bus.sub == OP_SUB) ? ~bus.B : bus.B;
   assign c0 = (bus.sub == OP_SUB) ? ~bus.Cin : bus.Cin;
   // the whole pipe advances together; only a held, unconsumed result stalls it
   assign en           = ~g_st[L].v_q | bus.out_ready;
   assign bus.in_ready = en;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int RI = WIDTH - k * CHUNK;
      // a_in/b_in carry only the operand bits not yet summed: chunk k sits at the bottom
      logic [RI-1:0]          a_in;
      logic [RI-1:0]          b_in;
      logic                   c_in;
      logic                   v_in;
      logic [CHUNK-1:0]       s;
      logic                   co;
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*CHUNK-1:0] y_d;
      logic [(k+1)*CHUNK-1:0] y_q;
      if (k == 0) begin : g_head
         assign a_in = bus.A;
         assign b_in = bx;
         assign c_in = c0;
         assign v_in = bus.in_valid;
         assign y_d  = s;
      end else begin : g_tail
         assign a_in = g_st[k-1].g_skew.a_q;
         assign b_in = g_st[k-1].g_skew.b_q;
         assign c_in = g_st[k-1].c_q;
         assign v_in = g_st[k-1].v_q;
         assign y_d  = {s, g_st[k-1].y_q};
      end
      pipelined_adder_slice #(.CHUNK(CHUNK)) u_slice (
         .a    (a_in[CHUNK-1:0]),
         .b    (b_in[CHUNK-1:0]),
         .cin  (c_in),
         .s    (s),
         .cout (co)
      );
      // upper operand chunks ride along so each operation occupies a single stage
      if (k < STAGES - 1) begin : g_skew
         logic [RI-CHUNK-1:0] a_q;
         logic [RI-CHUNK-1:0] b_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en && v_in) begin
               a_q <= a_in[RI-1:CHUNK];
               b_q <= b_in[RI-1:CHUNK];
            end
         end
      end
      // data only loads for valid slots, so results and flags hold through bubbles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            y_q <= '0;
         end else if (en) begin
            v_q <= v_in;
            if (v_in) begin
               c_q <= co;
               y_q <= y_d;
            end
         end
      end
   end
   // the last slice sees the operand sign bits, so overflow is decided there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         has_q <= 1'b0;
      end else if (en && g_st[L].v_in) begin
         ovf_q <= (g_st[L].a_in[CHUNK-1] == g_st[L].b_in[CHUNK-1]) &
                  (g_st[L].s[CHUNK-1] != g_st[L].a_in[CHUNK-1]);
         has_q <= 1'b1;
      end
   end
   assign bus.out_valid = g_st[L].v_q;
   assign bus.Y         = g_st[L].y_q;
   assign bus.Cout      = g_st[L].c_q;
   assign bus.ovf       = ovf_q;
   // has_q keeps zero low until a real result has reached the output
   assign bus.zero      = has_q & ~|g_st[L].y_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of the 32-bit/4-stage adder plus exhaustive 4-bit sweeps at 1, 2 and 4 stages
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   pipelined_adder_if #(.WIDTH(32)) bus ();
   pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   logic [2:0]      sw_iv;
   logic [2:0]      sw_or;
   logic [2:0]      sw_ir;
   logic [2:0]      sw_ov;
   logic [2:0][9:0] sw_vec;
   logic [2:0][6:0] sw_res;
   pipelined_adder_if #(.WIDTH(4)) sw_if [3] ();
   for (genvar g = 0; g < 3; g++) begin : g_sw
      pipelined_adder #(.WIDTH(4), .STAGES(1 << g)) u_sw (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (sw_if[g])
      );
      assign sw_if[g].in_valid  = sw_iv[g];
      assign sw_if[g].A         = sw_vec[g][3:0];
      assign sw_if[g].B         = sw_vec[g][7:4];
      assign sw_if[g].Cin       = sw_vec[g][8];
      assign sw_if[g].sub       = sw_vec[g][9];
      assign sw_if[g].out_ready = sw_or[g];
      assign sw_ir[g]  = sw_if[g].in_ready;
      assign sw_ov[g]  = sw_if[g].out_valid;
      assign sw_res[g] = {sw_if[g].Y, sw_if[g].Cout, sw_if[g].ovf, sw_if[g].zero};
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // behavioural 4-bit reference: vector index = {sub, Cin, B, A}; returns {Y, Cout, ovf, zero}
   function automatic logic [6:0] model(input int idx);
      int a, b, ci, sa, sb, t, st;
      logic [3:0] y;
      logic co, ov;
      a  = idx & 15;
      b  = (idx >> 4) & 15;
      ci = (idx >> 8) & 1;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      if (((idx >> 9) & 1) == 0) begin
         t  = a + b + ci;
         st = sa + sb + ci;
         co = t > 15;
      end else begin
         t  = a - b - ci;
         st = sa - sb - ci;
         co = a >= b + ci;
      end
      y  = 4'(t);
      ov = st > 7 || st < -8;
      return {y, co, ov, y == 4'd0};
   endfunction
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sb, input logic [31:0] ey, input logic ec, input logic eo, input logic ez);
      @(negedge clk);
      bus.A         = a;
      bus.B         = b;
      bus.Cin       = cin;
      bus.sub       = sb;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         chk($sformatf("%s_valid_edge%0d", tag, i), 64'(bus.out_valid), 64'(i == 4));
      end
      chk({tag, "_y"}, 64'(bus.Y), 64'(ey));
      chk({tag, "_cout"}, 64'(bus.Cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
      chk({tag, "_zero"}, 64'(bus.zero), 64'(ez));
   endtask
   initial begin
      int sent, recv, stall, gaps, vcnt;
      bit started;
      int nxt [3];
      int oc [3];
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.Cin       = 1'b0;
      bus.sub       = OP_ADD;
      bus.out_ready = 1'b1;
      sw_iv         = '0;
      sw_or         = '1;
      sw_vec        = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
      chk("reset_y", 64'(bus.Y), 64'(0));
      chk("reset_cout", 64'(bus.Cout), 64'(0));
      chk("reset_ovf", 64'(bus.ovf), 64'(0));
      chk("reset_zero", 64'(bus.zero), 64'(0));
      chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
      rst_n = 1'b1;
      run_op("t1_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_op("t2_sovf", 32'h7FFF_FFFF, 32'd1, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_op("t3_sub57", 32'd5, 32'd7, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_op("t3_sub75b", 32'd7, 32'd5, 1'b1, OP_SUB, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      run_op("t3_subovf", 32'h8000_0000, 32'd1, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      // 8 back-to-back ops, consumer stalls 3 cycles once 3 results have been taken
      sent    = 0;
      recv    = 0;
      stall   = 0;
      gaps    = 0;
      started = 1'b0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         @(negedge clk);
         bus.in_valid  = sent < 8;
         bus.A         = {8'(sent), 24'hFF_FFFF};
         bus.B         = 32'd1;
         bus.Cin       = 1'b0;
         bus.sub       = OP_ADD;
         bus.out_ready = !(recv == 3 && stall < 3);
         #1;
         if (!bus.out_ready) begin
            chk($sformatf("stall%0d_in_ready", stall), 64'(bus.in_ready), 64'(0));
            chk($sformatf("stall%0d_out_valid", stall), 64'(bus.out_valid), 64'(1));
            chk($sformatf("stall%0d_y", stall), 64'(bus.Y), 64'({8'(recv + 1), 24'h0}));
            stall++;
         end
         if (started && !bus.out_valid) gaps++;
         if (bus.in_valid && bus.in_ready) sent++;
         if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("stream_res%0d", recv), 64'(bus.Y), 64'({8'(recv + 1), 24'h0}));
            recv++;
            started = 1'b1;
         end
      end
      chk("stream_count", 64'(recv), 64'(8));
      chk("stream_gaps", 64'(gaps), 64'(0));
      chk("stream_stall_cycles", 64'(stall), 64'(3));
      // async reset with 3 ops in flight
      @(negedge clk);
      bus.A         = 32'hFFFF_FFFF;
      bus.B         = 32'd1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("inflight_out_valid", 64'(bus.out_valid), 64'(1));
      chk("inflight_zero", 64'(bus.zero), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("async_rst_cout", 64'(bus.Cout), 64'(0));
      chk("async_rst_zero", 64'(bus.zero), 64'(0));
      chk("async_rst_y", 64'(bus.Y), 64'(0));
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      vcnt          = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) vcnt++;
      end
      chk("post_rst_stale_results", 64'(vcnt), 64'(0));
      // exhaustive 4-bit sweep with random bubbles and backpressure on all three depths
      for (int j = 0; j < 3; j++) begin
         nxt[j] = 0;
         oc[j]  = 0;
      end
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (oc[0] == 1024 && oc[1] == 1024 && oc[2] == 1024) break;
         @(negedge clk);
         for (int j = 0; j < 3; j++) begin
            sw_iv[j]  = (nxt[j] < 1024) && ($urandom_range(0, 3) != 0);
            sw_vec[j] = 10'(nxt[j]);
            sw_or[j]  = $urandom_range(0, 3) != 0;
         end
         #1;
         for (int j = 0; j < 3; j++) begin
            if (sw_iv[j] && sw_ir[j]) nxt[j]++;
            if (sw_ov[j] && sw_or[j]) begin
               chk($sformatf("sweep_s%0d_v%0d", 1 << j, oc[j]), 64'(sw_res[j]), 64'(model(oc[j])));
               oc[j]++;
            end
         end
      end
      for (int j = 0; j < 3; j++) chk($sformatf("sweep_s%0d_count", 1 << j), 64'(oc[j]), 64'(1024));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
